// File: rtl/escalonador_atributos.sv
// escalonador_atributos: schedules every update of the pet attributes
// (0 fome, 1 felicidade, 2 sono) through one valid/ready update port.
// Periodic decay timers and user action pulses raise sticky pending flags.
// An IDLE/OFFER/MORTO FSM arbitrates between the flags and offers one update at a time.
// Optional build macro: ANTI_STARVE_EN. When it is defined, a decay flag that
// has waited through 8 action grants outranks every action until it is served.
module escalonador_atributos #(
  parameter int unsigned TICK_DIV     = 50000000,
  parameter int unsigned PER_FOME     = 10,
  parameter int unsigned PER_FEL      = 15,
  parameter int unsigned PER_SONO     = 20,
  parameter logic [7:0]  ACT_AMT      = 8'd20,
  parameter logic [7:0]  DECAY_AMT    = 8'd1,
  parameter logic [3:0]  EST_DORMINDO = 4'd3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] estado,
  input  logic [2:0] req_acao,
  input  logic       morreu,
  output logic       upd_valid,
  input  logic       upd_ready,
  output logic [1:0] upd_attr,
  output logic       upd_op,
  output logic [7:0] upd_amt,
  output logic       morto
);

  localparam int unsigned PMAX = (PER_FOME > PER_FEL) ?
                                 ((PER_FOME > PER_SONO) ? PER_FOME : PER_SONO) :
                                 ((PER_FEL > PER_SONO) ? PER_FEL : PER_SONO);
  localparam int PW = $clog2(PMAX + 1);
  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OFFER = 2'd1,
    MORTO = 2'd2
  } state_t;

  state_t        state, state_next;
  logic [TW-1:0] tick_cnt;
  logic          tick;
  logic          running;
  logic [2:0]    act;
  logic [2:0]    dec;
  logic [2:0]    per_wrap;
  logic [1:0]    rr_ptr;
  logic          cur_dec;
  logic          transfer;
  logic          grant_any;
  logic          grant_dec;
  logic          grant_take;
  logic          grant_op;
  logic [1:0]    grant_attr;
  logic [7:0]    grant_amt;
  logic [2:0]    dec_pick;
`ifdef ANTI_STARVE_EN
  logic [2:0]    starved;
  logic [2:0]    starve_pick;
`endif

  function automatic int unsigned period_of(input int i);
    case (i)
      0:       return PER_FOME;
      1:       return PER_FEL;
      default: return PER_SONO;
    endcase
  endfunction

  // Round-robin search over three requesters starting at ptr; returns {found, index}.
  function automatic logic [2:0] rr_pick(input logic [2:0] req, input logic [1:0] ptr);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int k = 2; k >= 0; k--) begin
      idx = 2'((32'(ptr) + 32'(k)) % 32'd3);
      if (req[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  assign running   = (state != MORTO);
  assign tick      = running && (tick_cnt == TW'(TICK_DIV - 1));
  assign transfer  = (state == OFFER) && upd_ready;
  assign upd_valid = (state == OFFER);
  assign morto     = (state == MORTO);

  // Base tick divider, frozen once the pet is dead
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt <= '0;
    end else if (running) begin
      tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_attr
      localparam int unsigned PER = period_of(gi);
      logic [PW-1:0] per_cnt;
      logic          act_f;
      logic          dec_f;
      logic          clr_act;
      logic          clr_dec;

      assign per_wrap[gi] = (per_cnt == PW'(PER - 1));
      assign clr_act      = transfer && !cur_dec && (upd_attr == 2'(gi));
      assign clr_dec      = transfer &&  cur_dec && (upd_attr == 2'(gi));
      assign act[gi]      = act_f;
      assign dec[gi]      = dec_f;

      // Period counter: counts base ticks and wraps at PER-1
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          per_cnt <= '0;
        end else if (tick) begin
          per_cnt <= per_wrap[gi] ? '0 : per_cnt + 1'b1;
        end
      end

      // Sticky pending flags: a new request in the clearing cycle keeps the flag set
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          act_f <= 1'b0;
          dec_f <= 1'b0;
        end else if (!running) begin
          act_f <= 1'b0;
          dec_f <= 1'b0;
        end else begin
          act_f <= req_acao[gi] | (act_f & ~clr_act);
          dec_f <= (tick & per_wrap[gi]) | (dec_f & ~clr_dec);
        end
      end

`ifdef ANTI_STARVE_EN
      logic [3:0] starve_cnt;
      assign starved[gi] = dec_f & starve_cnt[3];

      // Starvation counter: counts action grants that bypassed this pending decay
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          starve_cnt <= 4'd0;
        end else if (!running) begin
          starve_cnt <= 4'd0;
        end else if (grant_take && grant_dec && (grant_attr == 2'(gi))) begin
          starve_cnt <= 4'd0;
        end else if (grant_take && !grant_dec && dec_f && !starve_cnt[3]) begin
          starve_cnt <= starve_cnt + 4'd1;
        end
      end
`endif
    end
  endgenerate

  // Arbitration: later assignments override earlier ones, so they are written lowest priority first
  always_comb begin
    dec_pick   = rr_pick(dec, rr_ptr);
    grant_any  = 1'b0;
    grant_dec  = 1'b0;
    grant_attr = 2'd0;
    if (dec_pick[2]) begin
      grant_any  = 1'b1;
      grant_dec  = 1'b1;
      grant_attr = dec_pick[1:0];
    end
    if (act != 3'b000) begin
      grant_any  = 1'b1;
      grant_dec  = 1'b0;
      grant_attr = act[0] ? 2'd0 : (act[1] ? 2'd1 : 2'd2);
    end
`ifdef ANTI_STARVE_EN
    starve_pick = rr_pick(starved, rr_ptr);
    if (starve_pick[2]) begin
      grant_any  = 1'b1;
      grant_dec  = 1'b1;
      grant_attr = starve_pick[1:0];
    end
`endif
    grant_take = (state == IDLE) && !morreu && grant_any;
    grant_amt  = grant_dec ? DECAY_AMT : ACT_AMT;
    // Sleeping turns the sono decay into a restore
    grant_op   = grant_dec ? ((grant_attr == 2'd2) && (estado == EST_DORMINDO)) : 1'b1;
  end

  // Next-state logic: death is honoured in IDLE or right after the in-flight transfer
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (morreu)         state_next = MORTO;
        else if (grant_any) state_next = OFFER;
      end
      OFFER: begin
        if (upd_ready) state_next = morreu ? MORTO : IDLE;
      end
      MORTO:   state_next = MORTO;
      default: state_next = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Latch the granted update and advance the decay round-robin pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      upd_attr <= 2'd0;
      upd_op   <= 1'b0;
      upd_amt  <= 8'd0;
      cur_dec  <= 1'b0;
      rr_ptr   <= 2'd0;
    end else if (grant_take) begin
      upd_attr <= grant_attr;
      upd_op   <= grant_op;
      upd_amt  <= grant_amt;
      cur_dec  <= grant_dec;
      if (grant_dec) rr_ptr <= (grant_attr == 2'd2) ? 2'd0 : grant_attr + 2'd1;
    end
  end

endmodule

// File: tb/tb_escalonador_atributos.sv
// Bench for escalonador_atributos with small timer parameters.
// A cycle-level reference model predicts every output from the rules of the design.
// Decay events are taken as multiples of TICK_DIV*PER_x edges since reset.
// Honours ANTI_STARVE_EN when the bundle is built with that macro.
module tb_escalonador_atributos;

  localparam int         TD    = 4;
  localparam int         PF    = 2;
  localparam int         PL    = 3;
  localparam int         PS    = 5;
  localparam logic [7:0] AAMT  = 8'd20;
  localparam logic [7:0] DAMT  = 8'd1;
  localparam logic [3:0] EST_D = 4'd3;
`ifdef ANTI_STARVE_EN
  localparam bit ANTI = 1'b1;
`else
  localparam bit ANTI = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] estado = 4'd0;
  logic [2:0] req_acao = 3'd0;
  logic       morreu = 1'b0;
  logic       upd_valid;
  logic       upd_ready = 1'b0;
  logic [1:0] upd_attr;
  logic       upd_op;
  logic [7:0] upd_amt;
  logic       morto;

  always #5 clk = ~clk;

  escalonador_atributos #(
    .TICK_DIV(TD), .PER_FOME(PF), .PER_FEL(PL), .PER_SONO(PS),
    .ACT_AMT(AAMT), .DECAY_AMT(DAMT), .EST_DORMINDO(EST_D)
  ) dut (
    .clk(clk), .rst_n(rst_n), .estado(estado), .req_acao(req_acao),
    .morreu(morreu), .upd_valid(upd_valid), .upd_ready(upd_ready),
    .upd_attr(upd_attr), .upd_op(upd_op), .upd_amt(upd_amt), .morto(morto)
  );

  int n_checks = 0;
  int n_fail = 0;

  // Reference model state
  bit       m_off, m_dead, m_isdec;
  int       m_attr, m_op, m_amt, m_ptr, m_n;
  bit [2:0] m_act, m_dec;
  int       m_st[3];

  // Observation bookkeeping
  int         edge_no;
  bit         prev_valid, rose;
  logic [1:0] prev_attr;
  logic       prev_op;
  logic [7:0] prev_amt;
  int         xf_attr[$], xf_op[$], xf_amt[$], xf_edge[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h (edge %0d)", tag, obs, exp, edge_no);
    end
  endtask

  function automatic int period(input int x);
    case (x)
      0:       return TD * PF;
      1:       return TD * PL;
      default: return TD * PS;
    endcase
  endfunction

  function automatic int pick_rr(input bit [2:0] req, input int ptr);
    for (int k = 0; k < 3; k++)
      if (req[(ptr + k) % 3]) return (ptr + k) % 3;
    return -1;
  endfunction

  task automatic model_reset();
    m_off = 0; m_dead = 0; m_isdec = 0;
    m_attr = 0; m_op = 0; m_amt = 0; m_ptr = 0; m_n = 0;
    m_act = 3'b000; m_dec = 3'b000;
    for (int x = 0; x < 3; x++) m_st[x] = 0;
  endtask

  // One clock edge of the reference behaviour, using the inputs present at the edge
  task automatic model_edge();
    int       g;
    bit       gdec;
    bit       xfer;
    bit [2:0] smask;
    if (m_dead) return;
    xfer = m_off && upd_ready;
    g = -1;
    gdec = 0;
    if (!m_off && !morreu) begin
      for (int x = 0; x < 3; x++) smask[x] = m_dec[x] && (m_st[x] >= 8);
      if (ANTI) g = pick_rr(smask, m_ptr);
      if (g >= 0) gdec = 1;
      else if (m_act != 3'b000) begin
        for (int x = 2; x >= 0; x--) if (m_act[x]) g = x;
      end else begin
        g = pick_rr(m_dec, m_ptr);
        gdec = (g >= 0);
      end
    end
    if (g >= 0 && !gdec) begin
      for (int x = 0; x < 3; x++) if (m_dec[x] && m_st[x] < 8) m_st[x]++;
    end
    if (g >= 0 && gdec) m_st[g] = 0;
    m_n++;
    for (int x = 0; x < 3; x++) begin
      m_act[x] = req_acao[x] | (m_act[x] & !(xfer && !m_isdec && m_attr == x));
      m_dec[x] = (m_n % period(x) == 0) | (m_dec[x] & !(xfer && m_isdec && m_attr == x));
    end
    if (m_off) begin
      if (upd_ready) begin
        m_off = 0;
        if (morreu) m_dead = 1;
      end
    end else if (morreu) begin
      m_dead = 1;
    end else if (g >= 0) begin
      m_off = 1;
      m_attr = g;
      m_isdec = gdec;
      m_amt = gdec ? int'(DAMT) : int'(AAMT);
      m_op = gdec ? ((g == 2 && estado == EST_D) ? 1 : 0) : 1;
      if (gdec) m_ptr = (g + 1) % 3;
    end
  endtask

  // Advance one clock, log any transfer, update the model, compare all outputs
  task automatic step();
    @(posedge clk);
    if (prev_valid && upd_ready) begin
      xf_attr.push_back(int'(prev_attr));
      xf_op.push_back(int'(prev_op));
      xf_amt.push_back(int'(prev_amt));
      xf_edge.push_back(edge_no + 1);
      $display("xfer edge=%0d attr=%0d op=%0d amt=%0d", edge_no + 1, prev_attr, prev_op, prev_amt);
    end
    model_edge();
    edge_no++;
    #1;
    check("valid", upd_valid, m_off);
    check("morto", morto, m_dead);
    if (m_off) begin
      check("attr", upd_attr, m_attr);
      check("op", upd_op, m_op);
      check("amt", upd_amt, m_amt);
    end
    rose = upd_valid && !prev_valid;
    prev_valid = upd_valid;
    prev_attr = upd_attr;
    prev_op = upd_op;
    prev_amt = upd_amt;
  endtask

  task automatic clear_log();
    xf_attr.delete(); xf_op.delete(); xf_amt.delete(); xf_edge.delete();
  endtask

  // Asynchronous reset: outputs must drop without waiting for a clock edge
  task automatic do_reset();
    req_acao = 3'd0;
    morreu = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rst_valid", upd_valid, 0);
    check("rst_morto", morto, 0);
    check("rst_attr", upd_attr, 0);
    check("rst_op", upd_op, 0);
    check("rst_amt", upd_amt, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    edge_no = 0;
    prev_valid = 0;
    clear_log();
  endtask

  task automatic wait_offer(input string tag);
    for (int i = 0; i < 60 && !m_off; i++) step();
    check(tag, m_off, 1);
  endtask

  initial begin
    int fome_rise[$];
    int p0, cnt, found;
    edge_no = 0;
    prev_valid = 0;
    model_reset();

    // Reset state
    do_reset();

    // Periodic fome decay with ready held high
    upd_ready = 1'b1;
    for (int i = 0; i < 30; i++) begin
      step();
      if (rose && upd_attr == 2'd0) fome_rise.push_back(edge_no);
    end
    check("fome_rise_count", fome_rise.size() >= 3, 1);
    if (fome_rise.size() >= 3) begin
      check("fome_first", fome_rise[0], TD * PF + 1);
      check("fome_second", fome_rise[1], 2 * TD * PF + 1);
      check("fome_third", fome_rise[2], 3 * TD * PF + 1);
    end

    // Three simultaneous action pulses
    for (int i = 0; i < 40 && (m_off || m_dec != 0 || m_act != 0); i++) step();
    check("idle_before_burst", m_off || m_dec != 0, 0);
    clear_log();
    req_acao = 3'b111;
    step();
    req_acao = 3'b000;
    for (int i = 0; i < 7; i++) step();
    check("burst_count", xf_attr.size() >= 3, 1);
    if (xf_attr.size() >= 3) begin
      for (int k = 0; k < 3; k++) begin
        check("burst_attr", xf_attr[k], k);
        check("burst_op", xf_op[k], 1);
        check("burst_amt", xf_amt[k], AAMT);
      end
      check("burst_gap1", xf_edge[1] - xf_edge[0], 2);
      check("burst_gap2", xf_edge[2] - xf_edge[1], 2);
    end

    // All three decays at once (edge 120 is a common multiple of 8, 12, 20)
    for (int i = 0; i < 200 && edge_no < 120; i++) step();
    check("reach_120", edge_no, 120);
    p0 = m_ptr;
    clear_log();
    for (int i = 0; i < 8; i++) step();
    check("rr_count", xf_attr.size() >= 3, 1);
    if (xf_attr.size() >= 3) begin
      for (int k = 0; k < 3; k++) begin
        check("rr_attr", xf_attr[k], (p0 + k) % 3);
        check("rr_op", xf_op[k], 0);
      end
    end

    // Stall for 10 cycles with repeated play requests during the stall
    wait_offer("wait_stall");
    clear_log();
    upd_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      req_acao = (i >= 2 && i <= 6) ? 3'b010 : 3'b000;
      step();
    end
    req_acao = 3'b000;
    upd_ready = 1'b1;
    for (int i = 0; i < 12; i++) step();
    cnt = 0;
    foreach (xf_attr[k]) if (xf_attr[k] == 1 && xf_op[k] == 1) cnt++;
    check("coalesce_play", cnt, 1);

    // Sleeping turns the sono decay into an increment
    estado = EST_D;
    clear_log();
    found = 0;
    for (int i = 0; i < 60 && found == 0; i++) begin
      step();
      foreach (xf_attr[k]) if (xf_attr[k] == 2 && xf_amt[k] == DAMT) found = 1 + (xf_op[k] == 1);
    end
    check("sleep_sono_op", found, 2);
    estado = 4'd0;

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      req_acao  = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
      upd_ready = ($urandom_range(0, 3) != 0);
      estado    = ($urandom_range(0, 1) == 1) ? EST_D : 4'($urandom_range(0, 15));
      step();
    end
    estado = 4'd0;

    // Continuous feed requests: decays only get through with anti-starvation
    upd_ready = 1'b1;
    req_acao = 3'b001;
    for (int i = 0; i < 4; i++) step();
    clear_log();
    for (int i = 0; i < 120; i++) step();
    found = 0;
    foreach (xf_attr[k]) if (xf_attr[k] == 0 && xf_op[k] == 0) found = 1;
    check("starve_fome_served", found, ANTI);
    req_acao = 3'b000;

    // Death during an offer
    wait_offer("wait_death");
    upd_ready = 1'b0;
    morreu = 1'b1;
    for (int i = 0; i < 3; i++) step();
    upd_ready = 1'b1;
    step();
    check("dead_morto", morto, 1);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      req_acao = 3'($urandom_range(0, 7));
      step();
      if (upd_valid) cnt++;
    end
    check("dead_no_valid", cnt, 0);

    // Reset asserted in the middle of an offer
    do_reset();
    upd_ready = 1'b0;
    wait_offer("wait_rst_offer");
    do_reset();
    upd_ready = 1'b1;
    for (int i = 0; i < 20; i++) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
